// File: rtl/alu_seq.sv
// Multi-cycle W-bit ALU: single-cycle ADD/LSH/RSH/XOR/AND plus iterative
// SHLN/SHRN (one bit per cycle) and an unsigned shift-add multiply.
module alu_seq #(
  parameter int W  = 8,
  parameter int AW = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   alu_cmd,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  input  logic         sc_i,
  output logic [W-1:0] rslt,
  output logic         sc_o,
  output logic         busy,
  output logic         done,
  output logic         state_dbg
);

  // Handshake: start is taken only while busy=0 (IDLE, including the done
  // cycle); busy covers the EXEC cycles; done pulses for one cycle when
  // rslt/sc_o update, and they hold until the next done.

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_LSH  = 3'b001;
  localparam logic [2:0] OP_RSH  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_SHLN = 3'b101;
  localparam logic [2:0] OP_SHRN = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [2:0]    op_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  acc;
  logic [W-1:0]  hi;
  logic          sc_q;
  logic [AW-1:0] cnt;

  logic [AW-1:0] n_amt;
  logic          multi;
  logic          accept;
  logic          finish;
  logic [W-1:0]  one_res;
  logic          one_sc;
  logic [W-1:0]  step_acc;
  logic [W-1:0]  step_hi;
  logic          step_sc;
  logic [W:0]    mul_sum;

  assign busy      = (state == EXEC);
  assign state_dbg = (state == EXEC);

  // Shift amounts beyond W are clamped; W steps already flush every bit.
  always_comb begin
    n_amt = inB[AW-1:0];
    if (inB[AW-1:0] > AW'(W)) n_amt = AW'(W);
    multi = (alu_cmd == OP_MUL) ||
            (((alu_cmd == OP_SHLN) || (alu_cmd == OP_SHRN)) && (n_amt != '0));
  end

  always_comb begin
    one_res = inA;
    one_sc  = 1'b0;
    case (alu_cmd)
      OP_ADD:  {one_sc, one_res} = {1'b0, inA} + {1'b0, inB} + {{W{1'b0}}, sc_i};
      OP_LSH:  {one_sc, one_res} = {inA, sc_i};
      OP_RSH:  {one_res, one_sc} = {sc_i, inA};
      OP_XOR:  one_res = inA ^ inB;
      OP_AND:  one_res = inA & inB;
      default: one_res = inA;
    endcase
  end

  // One iteration of the op in flight; MUL keeps {hi, acc} as the partial
  // product with the remaining multiplier bits in the low end of acc.
  always_comb begin
    step_acc = acc;
    step_hi  = hi;
    step_sc  = 1'b0;
    mul_sum  = {1'b0, hi} + (acc[0] ? {1'b0, a_q} : {(W+1){1'b0}});
    case (op_q)
      OP_SHLN: begin
        step_acc = {acc[W-2:0], sc_q};
        step_sc  = acc[W-1];
      end
      OP_SHRN: begin
        step_acc = {sc_q, acc[W-1:1]};
        step_sc  = acc[0];
      end
      default: begin
        step_hi  = mul_sum[W:1];
        step_acc = {mul_sum[0], acc[W-1:1]};
        step_sc  = |mul_sum[W:1];
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (multi) state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt == AW'(1)) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rslt <= '0;
      sc_o <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      op_q <= '0;
      a_q  <= '0;
      acc  <= '0;
      hi   <= '0;
      sc_q <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_q <= alu_cmd;
        a_q  <= inA;
        sc_q <= sc_i;
        hi   <= '0;
        acc  <= (alu_cmd == OP_MUL) ? inB : inA;
        if (multi) begin
          cnt <= (alu_cmd == OP_MUL) ? AW'(W) : n_amt;
        end else begin
          cnt  <= '0;
          rslt <= one_res;
          sc_o <= one_sc;
          done <= 1'b1;
        end
      end else if (state == EXEC) begin
        acc <= step_acc;
        hi  <= step_hi;
        cnt <= cnt - AW'(1);
        if (finish) begin
          rslt <= step_acc;
          sc_o <= step_sc;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (W=8): single-cycle ops, clamped and unclamped
// shifts, multiply, ignored start while busy, back-to-back ops and mid-op reset.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   alu_cmd;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic         sc_i;
  logic [W-1:0] rslt;
  logic         sc_o;
  logic         busy;
  logic         done;
  logic         state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W:0] exp_q[$];

  alu_seq #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_cmd(alu_cmd),
    .inA(inA), .inB(inB), .sc_i(sc_i), .rslt(rslt), .sc_o(sc_o),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drives one op, scrambles the operand inputs after the accepting edge,
  // optionally pokes an ignored ADD start while busy, then checks the result.
  task automatic run_op(input string tag, input logic [2:0] cmd, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic s, input logic [W-1:0] er,
                        input logic es, input int elat, input int ebusy, input int poke);
    int lat;
    int busy_cnt;
    bit seen;
    logic [W:0] exp_v;
    exp_q.push_back({es, er});
    @(negedge clk);
    alu_cmd = cmd; inA = a; inB = b; sc_i = s; start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    alu_cmd = 3'($urandom_range(0, 7));
    inA     = W'($urandom_range(0, 255));
    inB     = W'($urandom_range(0, 255));
    sc_i    = 1'($urandom_range(0, 1));
    lat = 0; busy_cnt = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == poke + 1) start = 1'b0;
      if (done) seen = 1;
      else if (busy) busy_cnt++;
      if (lat == poke && !seen) begin
        alu_cmd = 3'b000; inA = 8'hFF; inB = 8'hFF; sc_i = 1'b1; start = 1'b1;
      end
    end
    start = 1'b0;
    exp_v = exp_q.pop_front();
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(ebusy));
    check({tag, " busy_in_done"}, 32'(busy), 32'd0);
    check({tag, " rslt"}, 32'(rslt), 32'(exp_v[W-1:0]));
    check({tag, " sc_o"}, 32'(sc_o), 32'(exp_v[W]));
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " rslt_held"}, 32'(rslt), 32'(exp_v[W-1:0]));
  endtask

  initial begin
    int cnt;
    reset = 1'b1; start = 1'b1; alu_cmd = 3'b000; inA = 8'h11; inB = 8'h22; sc_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset done", 32'(done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rslt", 32'(rslt), 32'd0);
    check("reset sc_o", 32'(sc_o), 32'd0);
    check("reset state", 32'(state_dbg), 32'd0);
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("post_reset done", 32'(done), 32'd0);

    // tag, cmd, A, B, sc_i, rslt, sc_o, latency, busy cycles, poke
    run_op("add",       3'b000, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1, 0, 0);
    run_op("lsh",       3'b001, 8'hAA, 8'h00, 1'b1, 8'h55, 1'b1, 1, 0, 0);
    run_op("rsh",       3'b010, 8'h01, 8'h00, 1'b1, 8'h80, 1'b1, 1, 0, 0);
    run_op("xor",       3'b011, 8'hF0, 8'h3C, 1'b1, 8'hCC, 1'b0, 1, 0, 0);
    run_op("and",       3'b100, 8'hA5, 8'h0F, 1'b0, 8'h05, 1'b0, 1, 0, 0);
    run_op("shln3",     3'b101, 8'h81, 8'h03, 1'b0, 8'h08, 1'b0, 4, 3, 0);
    run_op("shln3_hiB", 3'b101, 8'h81, 8'hF3, 1'b1, 8'h0F, 1'b0, 4, 3, 0);
    run_op("shrn0",     3'b110, 8'h81, 8'h00, 1'b1, 8'h81, 1'b0, 1, 0, 0);
    run_op("shrn1",     3'b110, 8'h81, 8'h01, 1'b1, 8'hC0, 1'b1, 2, 1, 0);
    run_op("shln_clamp",3'b101, 8'h81, 8'h0F, 1'b1, 8'hFF, 1'b1, 9, 8, 0);
    run_op("mul_0f_11", 3'b111, 8'h0F, 8'h11, 1'b1, 8'hFF, 1'b0, 9, 8, 0);
    run_op("mul_10_10", 3'b111, 8'h10, 8'h10, 1'b0, 8'h00, 1'b1, 9, 8, 0);
    run_op("mul_ff_ff", 3'b111, 8'hFF, 8'hFF, 1'b0, 8'h01, 1'b1, 9, 8, 0);
    run_op("mul_poke",  3'b111, 8'h0F, 8'h11, 1'b0, 8'hFF, 1'b0, 9, 8, 2);

    // Back-to-back: ADD issued in the MUL done cycle
    @(negedge clk);
    alu_cmd = 3'b111; inA = 8'h03; inB = 8'h05; sc_i = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt = 0;
    while (!done && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("b2b mul latency", 32'(cnt), 32'd9);
    check("b2b mul rslt", 32'(rslt), 32'h0F);
    alu_cmd = 3'b000; inA = 8'h02; inB = 8'h03; sc_i = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("b2b add done", 32'(done), 32'd1);
    check("b2b add rslt", 32'(rslt), 32'h05);
    check("b2b add sc_o", 32'(sc_o), 32'd0);
    check("b2b add busy", 32'(busy), 32'd0);

    // Reset sampled at T+4 during a MUL
    @(negedge clk);
    alu_cmd = 3'b111; inA = 8'h0F; inB = 8'h11; sc_i = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort rslt", 32'(rslt), 32'd0);
    check("abort sc_o", 32'(sc_o), 32'd0);
    check("abort done", 32'(done), 32'd0);
    reset = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("abort no_done", 32'(cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
